ysyx_23060203_wbu: RTL and testbench
====================================

# ysyx_23060203_wbu

Write-back and commit stage; it consumes every instruction the execute stage hands downstream. It retires GPR writes, owns the machine-mode CSR file, and converts `ecall`, `mret` and `fence.i` commits into a pipeline flush plus PC redirect. For `fence.i` it also runs an I-cache invalidate handshake before the redirect.

## Interface
Parameters:
- `RESET_MSTATUS`, default `32'h0000_1800`: reset value of mstatus (MPP=M).
- `MVENDORID`, default `32'h7973_7978`: read-only value at 0xF11.
- `MARCHID`, default `32'd23060203`: read-only value at 0xF12.

Ports:
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low.
- `in_valid` in 1: execute stage has a result.
- `in_ready` out 1: wbu accepts it.
- `in_pc` in 32: PC of the committing instruction.
- `in_gpr_waddr` in 5: GPR destination; 0 means no write.
- `in_gpr_wdata` in 32: GPR write data.
- `in_csr_wen` in 1: CSR write request.
- `in_csr_waddr` in 12: CSR address.
- `in_csr_wdata` in 32: CSR write data.
- `in_exc` in 1: ecall.
- `in_ret` in 1: mret.
- `in_fencei` in 1: fence.i.
- `gpr_wen` out 1: GPR file write enable.
- `gpr_waddr` out 5: GPR file write address.
- `gpr_wdata` out 32: GPR file write data.
- `csr_raddr` in 12: decode-stage CSR read address.
- `csr_rdata` out 32: combinational read data.
- `flush` out 1: kill all younger in-flight instructions.
- `redirect_valid` out 1: fetch must restart at `redirect_pc`.
- `redirect_pc` out 32: restart address.
- `icache_inv_valid` out 1: I-cache invalidate request.
- `icache_inv_ready` in 1: invalidate complete / accepted.

## Operation
- Commit = `in_valid & in_ready`.
- `in_ready` = (state == RUN).
- GPR port is combinational from the commit:
  - `gpr_wen` = commit & `in_gpr_waddr` != 0 & ~`in_exc`.
  - `gpr_waddr` / `gpr_wdata` pass through.
- CSRs held: mstatus(0x300), mtvec(0x305), mscratch(0x340), mepc(0x341), mcause(0x342).
  - Write masking: mtvec[1:0] and mepc[1:0] are forced to 0 on write.
  - mstatus writable bits: MIE[3], MPIE[7], MPP[12:11]. MPP always reads 2'b11.
  - Writes to unimplemented or read-only addresses are ignored. Reads of unimplemented addresses return 0.
- Per-commit priority is `in_exc` > `in_ret` > `in_fencei`; a CSR write proceeds only when neither `in_exc` nor `in_ret` is set.
  - `in_exc`: mepc ← `in_pc`; mcause ← 11; MPIE ← MIE; MIE ← 0. Go to REDIR with target mtvec.
  - `in_ret`: MIE ← MPIE; MPIE ← 1. Go to REDIR with target mepc (value before any same-cycle update).
  - `in_fencei`: target ← `in_pc`+4. Go to FENCE.
- FSM (`redirect_pc` is a registered target):
  - RUN: normal commits.
  - FENCE: `icache_inv_valid`=1; go to REDIR on `icache_inv_ready`.
  - REDIR: `redirect_valid`=1 for exactly one cycle, then RUN.
- `flush` = (state != RUN).
- `csr_rdata` reflects architectural state only, with no bypass from the same-cycle write. Decode must stall on a pending CSR writer.

## Timing
- Reset values:
  - state RUN; `flush`=0, `redirect_valid`=0, `icache_inv_valid`=0; `redirect_pc`=0.
  - mstatus=`RESET_MSTATUS`; all other CSRs 0.
- GPR and CSR updates land on the commit edge; the new value is readable next cycle.
- Redirect latency after a commit at cycle T:
  - ecall/mret: `flush` and `redirect_valid` high in cycle T+1. `in_ready` low in T+1 and high in T+2.
  - fence.i: `flush` high from T+1 through the REDIR cycle. `icache_inv_valid` stays high until sampled with ready; minimum 2 cycles of flush.
- `in_valid` arriving while `flush`=1 is never accepted.
- `reset` asserted mid-FENCE drops `icache_inv_valid` asynchronously. No redirect is issued.

## Configuration
- `YSYX_23060203_WBU_MCYCLE_EN` defined: adds a 64-bit cycle counter.
  - Increments every cycle out of reset; resets to 0.
  - Readable at 0xB00 (low) and 0xB80 (high); also writable there.
  - A write overrides the increment for that half in that cycle.
- Undefined: no counter is instantiated, and 0xB00/0xB80 read 0.

## Structure
- Shared package:
  - CSR address constants.
  - mstatus bit-position constants.
  - mcause code constants.
  - WBU state enum {RUN, FENCE, REDIR}.
- One sub-module, `ysyx_23060203_csr_file`: registers, write masking, read mux and optional counter. The wbu top holds the FSM and the commit decode.

## Test plan
- Commit x5=0x1234 from pc 0x8000_0000 → `gpr_wen`=1, waddr=5, wdata=0x1234. Commit with waddr=0 → `gpr_wen`=0.
- Write mtvec=0x8000_0103, then ecall at pc 0x8000_0040 with MIE=1 → next cycle:
  - `flush`=1, `redirect_pc`=0x8000_0100.
  - mepc=0x8000_0040, mcause=11, MIE=0, MPIE=1.
- mret with mepc=0x8000_0044 → next cycle `redirect_pc`=0x8000_0044, MIE=1, MPIE=1, mstatus reads 0x1888.
- fence.i at 0x8000_0010 with `icache_inv_ready` held low 3 cycles → `flush` high 5 cycles, then `redirect_pc`=0x8000_0014. `in_ready`=0 throughout.
- Write 0xFFFF_FFFF to mstatus, then to 0xF11 → mstatus=0x1888, `csr_rdata`(0xF11)=`MVENDORID`, unimplemented 0x7C0 reads 0.
- With `YSYX_23060203_WBU_MCYCLE_EN`: write 0xB00=0xFFFF_FFFF → next cycle 0xB00 reads 0, 0xB80 reads 1. Without the macro both read 0.

Source files
------------

// File: rtl/ysyx_23060203_wbu_pkg.sv
// ysyx_23060203_wbu_pkg: CSR addresses, mstatus bit positions, mcause codes and WBU state enum
package ysyx_23060203_wbu_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;
  typedef enum logic [1:0] {WBU_RUN, WBU_FENCE, WBU_REDIR} wbu_state_e;
endpackage

// File: rtl/ysyx_23060203_csr_file.sv
// ysyx_23060203_csr_file: machine-mode CSRs with write masking and read mux
// Optional 64-bit cycle counter at 0xB00/0xB80 when YSYX_23060203_WBU_MCYCLE_EN is defined.
module ysyx_23060203_csr_file
  import ysyx_23060203_wbu_pkg::*;
#(
  parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800,
  parameter logic [31:0] MVENDORID     = 32'h7973_7978,
  parameter logic [31:0] MARCHID       = 32'd23060203
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wen,
  input  logic [11:0] waddr,
  input  logic [31:0] wdata,
  input  logic        exc,
  input  logic        ret,
  input  logic [31:0] pc,
  input  logic [11:0] raddr,
  output logic [31:0] rdata,
  output logic [31:0] mtvec,
  output logic [31:0] mepc
);
  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [31:0] mstatus, cyc_lo, cyc_hi;
  always_comb begin
    mie_d      = (wen && waddr == CSR_MSTATUS) ? wdata[MSTATUS_MIE] : mie_q;
    mpie_d     = (wen && waddr == CSR_MSTATUS) ? wdata[MSTATUS_MPIE] : mpie_q;
    mtvec_d    = (wen && waddr == CSR_MTVEC) ? {wdata[31:2], 2'b00} : mtvec_q;
    mscratch_d = (wen && waddr == CSR_MSCRATCH) ? wdata : mscratch_q;
    mepc_d     = (wen && waddr == CSR_MEPC) ? {wdata[31:2], 2'b00} : mepc_q;
    mcause_d   = (wen && waddr == CSR_MCAUSE) ? wdata : mcause_q;
    if (exc) begin
      mepc_d   = pc;
      mcause_d = MCAUSE_ECALL_M;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (ret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mie_q      <= RESET_MSTATUS[MSTATUS_MIE];
      mpie_q     <= RESET_MSTATUS[MSTATUS_MPIE];
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end
`ifdef YSYX_23060203_WBU_MCYCLE_EN
  logic [63:0] mcycle_q, mcycle_d;
  always_comb begin
    mcycle_d = mcycle_q + 64'd1;
    if (wen && waddr == CSR_MCYCLE) mcycle_d[31:0] = wdata;
    if (wen && waddr == CSR_MCYCLEH) mcycle_d[63:32] = wdata;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) mcycle_q <= '0;
    else mcycle_q <= mcycle_d;
  end
  assign cyc_lo = mcycle_q[31:0];
  assign cyc_hi = mcycle_q[63:32];
`else
  assign cyc_lo = '0;
  assign cyc_hi = '0;
`endif
  // MPP is hardwired to M-mode; only MIE/MPIE hold state
  always_comb begin
    mstatus = '0;
    mstatus[MSTATUS_MIE] = mie_q;
    mstatus[MSTATUS_MPIE] = mpie_q;
    mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end
  always_comb begin
    case (raddr)
      CSR_MSTATUS:   rdata = mstatus;
      CSR_MTVEC:     rdata = mtvec_q;
      CSR_MSCRATCH:  rdata = mscratch_q;
      CSR_MEPC:      rdata = mepc_q;
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MCYCLE:    rdata = cyc_lo;
      CSR_MCYCLEH:   rdata = cyc_hi;
      CSR_MVENDORID: rdata = MVENDORID;
      CSR_MARCHID:   rdata = MARCHID;
      default:       rdata = '0;
    endcase
  end
  assign mtvec = mtvec_q;
  assign mepc  = mepc_q;
endmodule

// File: rtl/ysyx_23060203_wbu.sv
// ysyx_23060203_wbu: write-back/commit stage with CSR file, flush/redirect FSM and fence.i invalidate
// Define YSYX_23060203_WBU_MCYCLE_EN to add the 64-bit cycle counter.
module ysyx_23060203_wbu
  import ysyx_23060203_wbu_pkg::*;
#(
  parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800,
  parameter logic [31:0] MVENDORID     = 32'h7973_7978,
  parameter logic [31:0] MARCHID       = 32'd23060203
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_gpr_waddr,
  input  logic [31:0] in_gpr_wdata,
  input  logic        in_csr_wen,
  input  logic [11:0] in_csr_waddr,
  input  logic [31:0] in_csr_wdata,
  input  logic        in_exc,
  input  logic        in_ret,
  input  logic        in_fencei,
  output logic        gpr_wen,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        icache_inv_valid,
  input  logic        icache_inv_ready
);
  wbu_state_e  state_q, state_d;
  logic [31:0] target_q, target_d, mtvec, mepc;
  logic        commit, exc, ret, fencei;
  assign in_ready = state_q == WBU_RUN;
  assign commit   = in_valid & in_ready;
  assign exc      = commit & in_exc;
  assign ret      = commit & in_ret & ~in_exc;
  assign fencei   = commit & in_fencei & ~in_exc & ~in_ret;
  assign gpr_wen   = commit & (in_gpr_waddr != 5'd0) & ~in_exc;
  assign gpr_waddr = in_gpr_waddr;
  assign gpr_wdata = in_gpr_wdata;
  ysyx_23060203_csr_file #(
    .RESET_MSTATUS(RESET_MSTATUS),
    .MVENDORID    (MVENDORID),
    .MARCHID      (MARCHID)
  ) u_csr (
    .clock(clock),
    .reset(reset),
    .wen  (commit & in_csr_wen & ~in_exc & ~in_ret),
    .waddr(in_csr_waddr),
    .wdata(in_csr_wdata),
    .exc  (exc),
    .ret  (ret),
    .pc   (in_pc),
    .raddr(csr_raddr),
    .rdata(csr_rdata),
    .mtvec(mtvec),
    .mepc (mepc)
  );
  // mret targets the pre-update mepc, which is what the flop holds this cycle
  always_comb begin
    state_d  = state_q == WBU_FENCE ? (icache_inv_ready ? WBU_REDIR : WBU_FENCE) :
               state_q == WBU_REDIR ? WBU_RUN :
               (exc | ret) ? WBU_REDIR : fencei ? WBU_FENCE : WBU_RUN;
    target_d = exc ? mtvec : ret ? mepc : fencei ? in_pc + 32'd4 : target_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= WBU_RUN;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end
  assign flush            = state_q != WBU_RUN;
  assign redirect_valid   = state_q == WBU_REDIR;
  assign icache_inv_valid = state_q == WBU_FENCE;
  assign redirect_pc      = target_q;
endmodule

// File: tb/tb_ysyx_23060203_wbu.sv
// tb_ysyx_23060203_wbu: directed self-checking bench for the write-back/commit stage
module tb_ysyx_23060203_wbu;
  logic        clock = 1'b0, reset = 1'b0;
  logic        in_valid = 0, in_ready;
  logic [31:0] in_pc = 0;
  logic [4:0]  in_gpr_waddr = 0;
  logic [31:0] in_gpr_wdata = 0;
  logic        in_csr_wen = 0;
  logic [11:0] in_csr_waddr = 0;
  logic [31:0] in_csr_wdata = 0;
  logic        in_exc = 0, in_ret = 0, in_fencei = 0;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [11:0] csr_raddr = 0;
  logic [31:0] csr_rdata;
  logic        flush, redirect_valid, icache_inv_valid, icache_inv_ready = 0;
  logic [31:0] redirect_pc;
  int nvec = 0, nerr = 0;

  ysyx_23060203_wbu dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_gpr_waddr(in_gpr_waddr), .in_gpr_wdata(in_gpr_wdata),
    .in_csr_wen(in_csr_wen), .in_csr_waddr(in_csr_waddr), .in_csr_wdata(in_csr_wdata),
    .in_exc(in_exc), .in_ret(in_ret), .in_fencei(in_fencei),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .icache_inv_valid(icache_inv_valid), .icache_inv_ready(icache_inv_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_exc = 0; in_ret = 0; in_fencei = 0;
    in_csr_wen = 0; in_gpr_waddr = 0; in_gpr_wdata = 0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    idle();
    in_valid = 1; in_csr_wen = 1; in_csr_waddr = a; in_csr_wdata = d;
    tick();
    idle();
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] a, input logic [31:0] e);
    csr_raddr = a;
    #1;
    chk(tag, csr_rdata, e);
  endtask

  initial begin
    #12;
    chk("rst_flush", {31'd0, flush}, 0);
    chk("rst_redir_valid", {31'd0, redirect_valid}, 0);
    chk("rst_inv_valid", {31'd0, icache_inv_valid}, 0);
    chk("rst_redir_pc", redirect_pc, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    csr_rd("rst_mstatus", 12'h300, 32'h0000_1800);
    csr_rd("rst_mtvec", 12'h305, 0);
    @(negedge clock);
    reset = 1;
    tick();

    in_valid = 1; in_pc = 32'h8000_0000; in_gpr_waddr = 5; in_gpr_wdata = 32'h1234;
    #1;
    chk("gpr_wen", {31'd0, gpr_wen}, 1);
    chk("gpr_waddr", {27'd0, gpr_waddr}, 5);
    chk("gpr_wdata", gpr_wdata, 32'h1234);
    in_gpr_waddr = 0;
    #1;
    chk("gpr_wen_x0", {31'd0, gpr_wen}, 0);
    in_valid = 0; in_gpr_waddr = 9;
    #1;
    chk("gpr_wen_novalid", {31'd0, gpr_wen}, 0);
    tick();
    idle();

    csr_wr(12'h305, 32'h8000_0103);
    csr_rd("mtvec_mask", 12'h305, 32'h8000_0100);
    csr_wr(12'h300, 32'h0000_0008);
    csr_rd("mstatus_mie", 12'h300, 32'h0000_1808);

    in_valid = 1; in_exc = 1; in_pc = 32'h8000_0040; in_gpr_waddr = 5;
    in_csr_wen = 1; in_csr_waddr = 12'h340; in_csr_wdata = 32'hDEAD_BEEF;
    #1;
    chk("ecall_gpr_wen", {31'd0, gpr_wen}, 0);
    tick();
    idle();
    in_valid = 1; in_gpr_waddr = 7;
    chk("ecall_flush", {31'd0, flush}, 1);
    chk("ecall_redir_valid", {31'd0, redirect_valid}, 1);
    chk("ecall_in_ready", {31'd0, in_ready}, 0);
    chk("ecall_redir_pc", redirect_pc, 32'h8000_0100);
    chk("flush_no_accept", {31'd0, gpr_wen}, 0);
    csr_rd("ecall_mepc", 12'h341, 32'h8000_0040);
    csr_rd("ecall_mcause", 12'h342, 32'd11);
    csr_rd("ecall_mstatus", 12'h300, 32'h0000_1880);
    csr_rd("ecall_no_csrw", 12'h340, 0);
    in_valid = 0;
    tick();
    idle();
    chk("ecall_t2_ready", {31'd0, in_ready}, 1);
    chk("ecall_t2_flush", {31'd0, flush}, 0);
    chk("ecall_t2_redir", {31'd0, redirect_valid}, 0);

    csr_wr(12'h341, 32'h8000_0047);
    csr_rd("mepc_mask", 12'h341, 32'h8000_0044);
    in_valid = 1; in_ret = 1;
    tick();
    idle();
    chk("mret_redir_valid", {31'd0, redirect_valid}, 1);
    chk("mret_redir_pc", redirect_pc, 32'h8000_0044);
    csr_rd("mret_mstatus", 12'h300, 32'h0000_1888);
    tick();

    in_valid = 1; in_fencei = 1; in_pc = 32'h8000_0010; icache_inv_ready = 0;
    tick();
    idle();
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("fence_c%0d_flush", c), {31'd0, flush}, 1);
      chk($sformatf("fence_c%0d_inv", c), {31'd0, icache_inv_valid}, 1);
      chk($sformatf("fence_c%0d_ready", c), {31'd0, in_ready}, 0);
      chk($sformatf("fence_c%0d_redir", c), {31'd0, redirect_valid}, 0);
      tick();
    end
    icache_inv_ready = 1;
    #1;
    chk("fence_c4_flush", {31'd0, flush}, 1);
    chk("fence_c4_inv", {31'd0, icache_inv_valid}, 1);
    tick();
    icache_inv_ready = 0;
    chk("fence_c5_flush", {31'd0, flush}, 1);
    chk("fence_c5_redir", {31'd0, redirect_valid}, 1);
    chk("fence_c5_inv", {31'd0, icache_inv_valid}, 0);
    chk("fence_c5_ready", {31'd0, in_ready}, 0);
    chk("fence_redir_pc", redirect_pc, 32'h8000_0014);
    tick();
    chk("fence_c6_flush", {31'd0, flush}, 0);
    chk("fence_c6_ready", {31'd0, in_ready}, 1);

    csr_wr(12'h300, 32'hFFFF_FFFF);
    csr_rd("mstatus_allones", 12'h300, 32'h0000_1888);
    csr_wr(12'hF11, 32'hFFFF_FFFF);
    csr_rd("mvendorid", 12'hF11, 32'h7973_7978);
    csr_rd("marchid", 12'hF12, 32'd23060203);
    csr_rd("unimpl_7c0", 12'h7C0, 0);

    csr_wr(12'hB00, 32'hFFFF_FFFF);
    tick();
`ifdef YSYX_23060203_WBU_MCYCLE_EN
    csr_rd("mcycle_lo", 12'hB00, 0);
    csr_rd("mcycle_hi", 12'hB80, 1);
`else
    csr_rd("mcycle_lo", 12'hB00, 0);
    csr_rd("mcycle_hi", 12'hB80, 0);
`endif

    in_valid = 1; in_fencei = 1; in_pc = 32'h8000_0200;
    tick();
    idle();
    chk("midfence_inv", {31'd0, icache_inv_valid}, 1);
    #2;
    reset = 0;
    #1;
    chk("async_inv_drop", {31'd0, icache_inv_valid}, 0);
    chk("async_flush_drop", {31'd0, flush}, 0);
    chk("async_redir_pc", redirect_pc, 0);
    @(negedge clock);
    reset = 1;
    tick();
    chk("post_rst_redir", {31'd0, redirect_valid}, 0);
    chk("post_rst_ready", {31'd0, in_ready}, 1);
    csr_rd("post_rst_mstatus", 12'h300, 32'h0000_1800);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
